// File: rtl/clk_divider_prog_if.sv
// Control/status bundle for clk_divider_prog. CLK_DIVIDER_SYNC_EN adds the sync input.
// Handshake: load is a one-cycle strobe with no ready; it is always accepted on the edge where it is high.
interface clk_divider_prog_if #(
    parameter int CNT_W = 32
);
    logic             en;
    logic             load;
    logic [CNT_W-1:0] div_in;
    logic [CNT_W-1:0] high_in;
`ifdef CLK_DIVIDER_SYNC_EN
    logic             sync;
`endif
    logic             O_CLK;
    logic             O_TICK;
    logic             O_PEND;

`ifdef CLK_DIVIDER_SYNC_EN
    modport master (output en, load, div_in, high_in, sync, input O_CLK, O_TICK, O_PEND);
    modport slave  (input en, load, div_in, high_in, sync, output O_CLK, O_TICK, O_PEND);
`else
    modport master (output en, load, div_in, high_in, input O_CLK, O_TICK, O_PEND);
    modport slave  (input en, load, div_in, high_in, output O_CLK, O_TICK, O_PEND);
`endif
endinterface

// File: rtl/clk_divider_prog.sv
// Runtime-programmable divider: period/high time reload only at a period boundary.
// Optional CLK_DIVIDER_SYNC_EN adds a sync input that restarts the period immediately.
module clk_divider_prog #(
    parameter int CNT_W        = 32,
    parameter int DEFAULT_DIV  = 20,
    parameter int DEFAULT_HIGH = 10
) (
    input  logic                 I_CLK,
    input  logic                 rst,
    clk_divider_prog_if.slave    bus
);
    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] HIGH_RST = CNT_W'(DEFAULT_HIGH);
    localparam logic [CNT_W-1:0] CNT_RST  = CNT_W'(DEFAULT_DIV - 1);
    localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_act_q, div_act_d;
    logic [CNT_W-1:0] high_act_q, high_act_d;
    logic [CNT_W-1:0] div_pnd_q, div_pnd_d;
    logic [CNT_W-1:0] high_pnd_q, high_pnd_d;
    logic             pend_q, pend_d;
    logic             o_clk_q, o_clk_d;
    logic             o_tick_q, o_tick_d;

    logic             boundary;
    logic             restart;
    logic [CNT_W-1:0] high_eff;
    logic [CNT_W-1:0] div_clamp;
    logic [CNT_W-1:0] high_clamp;

    always_comb begin
        boundary = (cnt_q == div_act_q - ONE);
`ifdef CLK_DIVIDER_SYNC_EN
        restart  = boundary | bus.sync;
`else
        restart  = boundary;
`endif
        div_clamp  = (bus.div_in < TWO) ? TWO : bus.div_in;
        if (bus.high_in == '0)
            high_clamp = ONE;
        else if (bus.high_in >= div_clamp)
            high_clamp = div_clamp - ONE;
        else
            high_clamp = bus.high_in;

        cnt_d      = cnt_q;
        div_act_d  = div_act_q;
        high_act_d = high_act_q;
        div_pnd_d  = div_pnd_q;
        high_pnd_d = high_pnd_q;
        pend_d     = pend_q;
        o_clk_d    = o_clk_q;
        o_tick_d   = 1'b0;
        high_eff   = high_act_q;

        if (bus.en) begin
            cnt_d = restart ? '0 : cnt_q + ONE;
            // A pending setting takes over on the restart edge so the new period begins at cnt 0.
            if (restart && pend_q) begin
                high_eff   = high_pnd_q;
                div_act_d  = div_pnd_q;
                high_act_d = high_pnd_q;
                pend_d     = 1'b0;
            end
            o_clk_d  = (cnt_d < high_eff);
            o_tick_d = (cnt_d == '0);
        end

        // A capture on the same edge wins over the clear above; it applies at the next boundary.
        if (bus.load) begin
            div_pnd_d  = div_clamp;
            high_pnd_d = high_clamp;
            pend_d     = 1'b1;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (rst) begin
            cnt_q      <= CNT_RST;
            div_act_q  <= DIV_RST;
            high_act_q <= HIGH_RST;
            div_pnd_q  <= DIV_RST;
            high_pnd_q <= HIGH_RST;
            pend_q     <= 1'b0;
            o_clk_q    <= 1'b0;
            o_tick_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            high_act_q <= high_act_d;
            div_pnd_q  <= div_pnd_d;
            high_pnd_q <= high_pnd_d;
            pend_q     <= pend_d;
            o_clk_q    <= o_clk_d;
            o_tick_q   <= o_tick_d;
        end
    end

    assign bus.O_CLK  = o_clk_q;
    assign bus.O_TICK = o_tick_q;
    assign bus.O_PEND = pend_q;
endmodule

// File: tb/tb_clk_divider_prog.sv
// Directed bench for clk_divider_prog: periods, clamps, enable freeze, reload timing, reset, sync.
module tb_clk_divider_prog;
    localparam int CNT_W = 32;

    logic I_CLK = 1'b0;
    logic rst   = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    clk_divider_prog_if #(.CNT_W(CNT_W)) bus ();

    clk_divider_prog #(.CNT_W(CNT_W), .DEFAULT_DIV(20), .DEFAULT_HIGH(10)) dut (
        .I_CLK (I_CLK),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 I_CLK = ~I_CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one I_CLK edge; outputs are then read 1 time unit after it.
    task automatic step();
        @(posedge I_CLK);
        #1;
    endtask

    // Counts edges until the next O_TICK, and how many observed states had O_CLK high.
    task automatic run_to_tick(output int steps, output int highs);
        steps = 0;
        highs = 0;
        do begin
            if (bus.O_CLK) highs++;
            steps++;
            step();
        end while (!bus.O_TICK && steps < 2000);
    endtask

    task automatic load_cfg(input logic [31:0] d, input logic [31:0] h);
        bus.load    = 1'b1;
        bus.div_in  = d;
        bus.high_in = h;
        step();
        bus.load    = 1'b0;
    endtask

    int s, h, frozen_bad;

    initial begin
        bus.en      = 1'b0;
        bus.load    = 1'b0;
        bus.div_in  = '0;
        bus.high_in = '0;
`ifdef CLK_DIVIDER_SYNC_EN
        bus.sync    = 1'b0;
`endif
        // Reset state
        step();
        bus.en = 1'b1;
        step();
        check_val("rst_clk",  32'(bus.O_CLK),  0);
        check_val("rst_tick", 32'(bus.O_TICK), 0);
        check_val("rst_pend", 32'(bus.O_PEND), 0);

        rst = 1'b0;
        step();
        check_val("first_clk",  32'(bus.O_CLK),  1);
        check_val("first_tick", 32'(bus.O_TICK), 1);

        // Defaults 20/10, two periods
        for (int i = 0; i < 2; i++) begin
            run_to_tick(s, h);
            check_val("def_period", s, 20);
            check_val("def_high",   h, 10);
        end

        // Mid-period load 7/3: old period finishes intact
        repeat (5) step();
        load_cfg(7, 3);
        check_val("mid_pend_set", 32'(bus.O_PEND), 1);
        run_to_tick(s, h);
        check_val("mid_rest_steps", s, 14);
        check_val("mid_rest_high",  h, 4);
        check_val("mid_pend_clr", 32'(bus.O_PEND), 0);
        for (int i = 0; i < 2; i++) begin
            run_to_tick(s, h);
            check_val("p7_period", s, 7);
            check_val("p7_high",   h, 3);
        end

        // Clamps
        load_cfg(0, 0);
        run_to_tick(s, h);
        run_to_tick(s, h);
        check_val("clamp00_period", s, 2);
        check_val("clamp00_high",   h, 1);
        load_cfg(5, 9);
        run_to_tick(s, h);
        run_to_tick(s, h);
        check_val("clamp59_period", s, 5);
        check_val("clamp59_high",   h, 4);

        // Back to 20/10, then freeze 13 cycles in the high phase
        load_cfg(20, 10);
        run_to_tick(s, h);
        repeat (3) step();
        bus.en = 1'b0;
        frozen_bad = 0;
        for (int i = 0; i < 13; i++) begin
            step();
            if (bus.O_CLK !== 1'b1 || bus.O_TICK !== 1'b0) frozen_bad++;
        end
        check_val("freeze_bad_cycles", frozen_bad, 0);
        bus.en = 1'b1;
        run_to_tick(s, h);
        check_val("freeze_rest_steps", s, 17);
        check_val("freeze_rest_high",  h, 7);

        // Load on the boundary edge, then overwrite before the next boundary
        repeat (19) step();
        load_cfg(9, 4);
        check_val("bnd_tick", 32'(bus.O_TICK), 1);
        check_val("bnd_pend", 32'(bus.O_PEND), 1);
        repeat (5) step();
        load_cfg(6, 2);
        run_to_tick(s, h);
        check_val("bnd_old_rest", s, 14);
        check_val("bnd_pend_clr", 32'(bus.O_PEND), 0);
        run_to_tick(s, h);
        check_val("bnd_new_period", s, 6);
        check_val("bnd_new_high",   h, 2);

        // Reset with a pending setting mid-period
        load_cfg(11, 5);
        step();
        rst = 1'b1;
        step();
        check_val("rst2_clk",  32'(bus.O_CLK),  0);
        check_val("rst2_pend", 32'(bus.O_PEND), 0);
        rst = 1'b0;
        step();
        check_val("rst2_first_tick", 32'(bus.O_TICK), 1);
        run_to_tick(s, h);
        check_val("rst2_period", s, 20);
        check_val("rst2_high",   h, 10);

`ifdef CLK_DIVIDER_SYNC_EN
        // Sync at cnt 4 restarts the period
        repeat (4) step();
        bus.sync = 1'b1;
        step();
        bus.sync = 1'b0;
        check_val("sync_clk",  32'(bus.O_CLK),  1);
        check_val("sync_tick", 32'(bus.O_TICK), 1);
        run_to_tick(s, h);
        check_val("sync_period", s, 20);
        check_val("sync_high",   h, 10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
